// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// error response value and request latencies.
// Optional feature macro: LSU_BYTE_OPS_EN (enables LB/LBU/SB).
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_SW  = 3'b001,
    OP_LB  = 3'b010,
    OP_LBU = 3'b011,
    OP_SB  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

  // Read data returned with any error or store response.
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // Cycles from acceptance to rsp_valid with rsp_ready held high.
  localparam int unsigned LAT_ERR  = 1;
  localparam int unsigned LAT_WORD = 2;
  localparam int unsigned LAT_SB   = 3;

  // True for op codes this build implements.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef LSU_BYTE_OPS_EN
    return op inside {OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB};
`else
    return op inside {OP_LW, OP_SW};
`endif
  endfunction

  // Word ops must be 4-byte aligned.
  function automatic logic op_is_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_is_store(input op_e op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: selects and extends a load byte and merges a store byte
// into a word. Without LSU_BYTE_OPS_EN the word passes straight through.
module lsu_byte_lane (
  input  logic [31:0] word,
`ifdef LSU_BYTE_OPS_EN
  input  logic [1:0]  lane,
  input  logic        byte_load,
  input  logic        sign_ext,
  input  logic [7:0]  store_byte,
  output logic [31:0] merged,
`endif
  output logic [31:0] load_data
);

`ifdef LSU_BYTE_OPS_EN
  logic [7:0] sel;

  // Little-endian lane select, extend for loads, lane replace for stores.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; that is what keeps latches from being inferred.
    sel       = word[{lane, 3'b000} +: 8];
    load_data = word;
    merged    = word;
    if (byte_load) begin
      load_data = {{24{sign_ext & sel[7]}}, sel};
    end
    merged[{lane, 3'b000} +: 8] = store_byte;
  end
`else
  assign load_data = word;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request FSM between a valid/ready
// request/response pair and a combinational-read, clocked-write word memory.
// Optional feature macro: LSU_BYTE_OPS_EN (LB/LBU/SB, WRITE state, merge).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [DEPTH_LOG2-1:0] widx_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  req_err;
  logic [31:0]           load_data;
`ifdef LSU_BYTE_OPS_EN
  logic [1:0]            lane_q;
  logic [31:0]           merged;
  logic [31:0]           merged_q;
`endif

  assign accept  = req_valid && req_ready;
  assign req_err = !op_legal(req_op)
                || (|req_addr[31:DEPTH_LOG2+2])
                || (op_is_word(req_op) && (|req_addr[1:0]));

`ifdef LSU_BYTE_OPS_EN
  lsu_byte_lane u_byte_lane (
    .word       (mem_rdata),
    .lane       (lane_q),
    .byte_load  ((op_q == OP_LB) || (op_q == OP_LBU)),
    .sign_ext   (op_q == OP_LB),
    .store_byte (wdata_q[7:0]),
    .merged     (merged),
    .load_data  (load_data)
  );
`else
  lsu_byte_lane u_byte_lane (
    .word      (mem_rdata),
    .load_data (load_data)
  );
`endif

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and memory/handshake outputs, decoded from the current state.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = rst_n;
        if (accept) state_d = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_addr = widx_q;
        if (op_q == OP_SW) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end
`ifdef LSU_BYTE_OPS_EN
        state_d = (op_q == OP_SB) ? ST_WRITE : ST_RESP;
`else
        state_d = ST_RESP;
`endif
      end
`ifdef LSU_BYTE_OPS_EN
      ST_WRITE: begin
        mem_addr  = widx_q;
        mem_we    = 1'b1;
        mem_wdata = merged_q;
        state_d   = ST_RESP;
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch on acceptance and response capture in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_LW;
      widx_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef LSU_BYTE_OPS_EN
      lane_q   <= '0;
      merged_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= op_e'(req_op);
            widx_q  <= req_addr[DEPTH_LOG2+1:2];
            wdata_q <= req_wdata;
            rdata_q <= ERR_RDATA;
            err_q   <= req_err;
`ifdef LSU_BYTE_OPS_EN
            lane_q  <= req_addr[1:0];
`endif
          end
        end
        ST_ACCESS: begin
          err_q   <= 1'b0;
          rdata_q <= op_is_store(op_q) ? ERR_RDATA : load_data;
`ifdef LSU_BYTE_OPS_EN
          merged_q <= merged;
`endif
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model predicts
// each response and memory write; directed requests pin literal values.
// Follows LSU_BYTE_OPS_EN the same way the design does.
module tb_load_store_unit;

  localparam int WORDS = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(.DEPTH_LOG2(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, clocked write.
  logic [31:0] dmem [WORDS];
  assign mem_rdata = dmem[mem_addr];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  int         we_pulses = 0;
  logic [4:0] last_we_addr = '0;
  always @(posedge clk) if (mem_we) begin
    we_pulses++;
    last_we_addr = mem_addr;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, actual, expected);
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum {M_IDLE, M_BUSY, M_RESP} mphase_e;
  mphase_e     m_phase = M_IDLE;
  int          m_rem, m_lat;
  logic [31:0] m_rdata, m_val;
  logic        m_err, m_store;
  logic [4:0]  m_idx;
  logic [31:0] ref_mem [WORDS];

  // Expected outcome of one request from the op/address rules.
  task automatic predict(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata, output int lat,
                         output logic store, output logic [4:0] idx, output logic [31:0] val);
    logic        legal, word_op;
    logic [31:0] w;
    logic [7:0]  b;
    int          sh;
    legal = (op == 3'd0) || (op == 3'd1);
`ifdef LSU_BYTE_OPS_EN
    legal = legal || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
`endif
    word_op = (op == 3'd0) || (op == 3'd1);
    idx   = addr[6:2];
    sh    = 8 * int'(addr[1:0]);
    w     = ref_mem[idx];
    b     = 8'(w >> sh);
    err   = 1'b0;
    rdata = 32'h0;
    lat   = 2;
    store = 1'b0;
    val   = 32'h0;
    if (!legal || addr >= 32'h80 || (word_op && addr[1:0] != 2'b00)) begin
      err = 1'b1;
      lat = 1;
    end else begin
      case (op)
        3'd0: rdata = w;
        3'd1: begin store = 1'b1; val = wdata; end
        3'd2: rdata = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
        3'd3: rdata = {24'h0, b};
        3'd4: begin
          store = 1'b1;
          lat   = 3;
          val   = (w & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_phase = M_IDLE;
    else begin
      case (m_phase)
        M_IDLE: if (req_valid) begin
          predict(req_op, req_addr, req_wdata, m_err, m_rdata, m_lat, m_store, m_idx, m_val);
          m_rem   = m_lat - 1;
          m_phase = (m_rem == 0) ? M_RESP : M_BUSY;
        end
        M_BUSY: begin
          if (m_rem == 1 && m_store) ref_mem[m_idx] = m_val;
          m_rem--;
          if (m_rem == 0) m_phase = M_RESP;
        end
        M_RESP: if (rsp_ready) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst req_ready", req_ready, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_err", rsp_err, 0);
      check("rst rsp_rdata", rsp_rdata, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
    end else begin
      check("req_ready", req_ready, m_phase == M_IDLE);
      check("rsp_valid", rsp_valid, m_phase == M_RESP);
      if (m_phase == M_RESP) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", rsp_err, m_err);
      end
      check("mem_we", mem_we, (m_phase == M_BUSY) && (m_rem == 1) && m_store);
      if (m_phase == M_BUSY) check("mem_addr", mem_addr, m_idx);
      if ((m_phase == M_BUSY) && (m_rem == 1) && m_store) check("mem_wdata", mem_wdata, m_val);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, input int exp_lat,
                      output logic [31:0] rdata, output logic err);
    int          n;
    logic [31:0] held;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    rsp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("req_ready before accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", n, exp_lat);
    held = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall rsp_valid", rsp_valid, 1);
      check("stall rsp_rdata", rsp_rdata, held);
      check("stall req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
    check("req_ready after handshake", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w0;
    for (int i = 0; i < WORDS; i++) begin
      dmem[i]    = (i < 11) ? 32'(i) : 32'h0;
      ref_mem[i] = (i < 11) ? 32'(i) : 32'h0;
    end
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("req_ready after release", req_ready, 1);

    // Plain word load.
    xfer(3'b000, 32'h14, 32'h0, 0, 2, rd, er);
    check("LW 0x14 rdata", rd, 32'h5);
    check("LW 0x14 err", er, 0);

    // Reset during the cycle after an SB is accepted.
    w0 = we_pulses;
    check("SB reset ready", req_ready, 1);
    req_valid = 1'b1; req_op = 3'b100; req_addr = 32'h9; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid rst req_ready", req_ready, 0);
    check("mid rst rsp_valid", rsp_valid, 0);
    check("mid rst mem_we", mem_we, 0);
    check("mid rst mem_addr", mem_addr, 0);
    check("mid rst rsp_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("ready first cycle after release", req_ready, 1);
    check("word2 kept after reset", dmem[2], 32'h2);
    check("no write across reset", we_pulses - w0, 0);

    // Word store then load back.
    w0 = we_pulses;
    xfer(3'b001, 32'h2C, 32'hDEADBEEF, 0, 2, rd, er);
    check("SW rdata", rd, 32'h0);
    check("SW err", er, 0);
    check("SW one pulse", we_pulses - w0, 1);
    check("SW pulse addr", last_we_addr, 11);
    xfer(3'b000, 32'h2C, 32'h0, 0, 2, rd, er);
    check("LW 0x2C rdata", rd, 32'hDEADBEEF);

    // Byte ops.
    w0 = we_pulses;
`ifdef LSU_BYTE_OPS_EN
    xfer(3'b100, 32'h09, 32'hAB, 0, 3, rd, er);
    check("SB rdata", rd, 32'h0);
    check("SB one pulse", we_pulses - w0, 1);
    check("SB word2", dmem[2], 32'h0000AB02);
    xfer(3'b010, 32'h09, 32'h0, 0, 2, rd, er);
    check("LB 0x09", rd, 32'hFFFFFFAB);
    xfer(3'b011, 32'h09, 32'h0, 0, 2, rd, er);
    check("LBU 0x09", rd, 32'h000000AB);
    xfer(3'b010, 32'h08, 32'h0, 0, 2, rd, er);
    check("LB 0x08", rd, 32'h00000002);
`else
    xfer(3'b100, 32'h09, 32'hAB, 0, 1, rd, er);
    check("SB illegal err", er, 1);
    check("SB illegal rdata", rd, 32'h0);
    check("SB no write", we_pulses - w0, 0);
    check("SB word2 kept", dmem[2], 32'h2);
    xfer(3'b010, 32'h09, 32'h0, 0, 1, rd, er);
    check("LB illegal err", er, 1);
    xfer(3'b011, 32'h09, 32'h0, 0, 1, rd, er);
    check("LBU illegal err", er, 1);
`endif

    // Error requests.
    w0 = we_pulses;
    xfer(3'b000, 32'h06, 32'h0, 0, 1, rd, er);
    check("LW misaligned err", er, 1);
    check("LW misaligned rdata", rd, 32'h0);
    xfer(3'b000, 32'h80, 32'h0, 0, 1, rd, er);
    check("LW out of range err", er, 1);
    check("LW out of range rdata", rd, 32'h0);
    xfer(3'b111, 32'h10, 32'h0, 0, 1, rd, er);
    check("op 111 err", er, 1);
    check("op 111 rdata", rd, 32'h0);
    xfer(3'b001, 32'h2E, 32'h1111, 0, 1, rd, er);
    check("SW misaligned err", er, 1);
    check("errors no write", we_pulses - w0, 0);

    // Response held under backpressure.
    xfer(3'b000, 32'h2C, 32'h0, 5, 2, rd, er);
    check("stalled LW rdata", rd, 32'hDEADBEEF);

    // Last legal word.
    xfer(3'b000, 32'h7C, 32'h0, 0, 2, rd, er);
    check("LW 0x7C", rd, 32'h0);
    xfer(3'b001, 32'h7C, 32'h12345678, 0, 2, rd, er);
    xfer(3'b000, 32'h7C, 32'h0, 0, 2, rd, er);
    check("LW 0x7C after SW", rd, 32'h12345678);
`ifdef LSU_BYTE_OPS_EN
    xfer(3'b011, 32'h7F, 32'h0, 0, 2, rd, er);
    check("LBU 0x7F", rd, 32'h00000012);
`endif

    // Final memory image against the model.
    repeat (2) @(posedge clk);
    for (int i = 0; i < WORDS; i++) check($sformatf("dmem[%0d]", i), dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5, meaning word-address width driven to the data memory (32 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_op (input, 3), req_addr (input, 32, byte address) and req_wdata (input, 32), forming the request channel.
REQ-005 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32) and rsp_err (output, 1), forming the response channel.
REQ-006 SHALL have ports mem_we (output, 1), mem_addr (output, DEPTH_LOG2, word address), mem_wdata (output, 32) and mem_rdata (input, 32, combinational read of mem_addr); the memory writes on posedge clk when mem_we=1.

Function
REQ-007 SHALL decode req_op as LW=000, SW=001, LB=010, LBU=011, SB=100; all other codes are illegal.
REQ-008 SHALL implement the states IDLE, ACCESS, WRITE and RESP.
REQ-009 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready, and op, addr and wdata are latched.
REQ-010 SHALL check on acceptance: illegal op, req_addr[31:DEPTH_LOG2+2] nonzero, or word op with addr[1:0]!=0 gives error; the FSM goes IDLE->RESP with rsp_err=1 and rsp_rdata=0, and mem_we is never asserted.
REQ-011 SHALL, on a legal request, go IDLE->ACCESS; in ACCESS mem_addr=latched addr[DEPTH_LOG2+1:2].
REQ-012 SHALL, for LW/LB/LBU, capture in ACCESS: LW the full word; LB the selected byte (addr[1:0], little-endian) sign-extended; LBU the same byte zero-extended. Then ACCESS->RESP.
REQ-013 SHALL, for SW, assert mem_we=1 with mem_wdata=latched wdata for exactly the ACCESS cycle, then ACCESS->RESP.
REQ-014 SHALL, for SB, read the word in ACCESS, merge wdata[7:0] into the byte lane addr[1:0], go ACCESS->WRITE, and assert mem_we=1 with the merged word for exactly the WRITE cycle, then WRITE->RESP.
REQ-015 SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err in RESP until rsp_ready=1, then go RESP->IDLE; stores return rsp_rdata=0.
REQ-016 SHALL meet these latencies with rsp_ready held high: error, rsp_valid 1 cycle after acceptance; LW/LB/LBU/SW, 2 cycles; SB, 3 cycles; next acceptance is one cycle after the handshake.
REQ-017 SHALL assert mem_we at most once per accepted request and never outside ACCESS/WRITE.

Reset
REQ-018 SHALL, while rst_n=0, force state=IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0 and mem_wdata=0, regardless of clk.
REQ-019 SHALL drop any in-flight request (including an SB between ACCESS and WRITE) on reset, with no memory write issued; req_ready=1 on the first cycle after release.

Configuration
REQ-020 SHALL support macro LSU_BYTE_OPS_EN: when defined, LB/LBU/SB behave per REQ-012/014; when undefined, LB/LBU/SB are illegal ops per REQ-010 and the WRITE state and merge logic are absent.

Structure
REQ-021 SHALL place the op encodings, the FSM state enum and the error/latency constants in package lsu_pkg.
REQ-022 SHALL place byte-lane select, extend and merge logic in one combinational sub-module lsu_byte_lane.

Verification (DataMem preloaded so that word i = i for i<11, else 0)
REQ-023 SHALL cover: LW addr 0x14 -> rsp_rdata=0x00000005, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-024 SHALL cover: SW 0x2C data 0xDEADBEEF, then LW 0x2C -> exactly one mem_we pulse at mem_addr=11, read 0xDEADBEEF.
REQ-025 SHALL cover: SB 0x09 data 0xAB -> word 2 = 0x0000AB02; then LB 0x09 -> 0xFFFFFFAB and LBU 0x09 -> 0x000000AB.
REQ-026 SHALL cover: LW 0x06 (misaligned), LW 0x80 (out of range) and op 111 -> rsp_err=1, rsp_rdata=0, mem_we never high.
REQ-027 SHALL cover: rsp_ready low 5 cycles during RESP -> rsp_valid and rsp_rdata held stable, req_ready=0 throughout.
REQ-028 SHALL cover: rst_n low in the ACCESS cycle of an SB to 0x09 -> no write, word 2 remains 0x00000002, outputs at reset values.
